// File: rtl/dtc_wbuf.sv
// dtc_wbuf: write buffer placed directly after the dtc output stage.
// Every write strobe is captured (address + data) into a DEPTH-entry FIFO.
// The FIFO drains to the memory-side sink over a valid/ready handshake. The
// dtc cannot be stalled, so a write that finds the buffer full is dropped,
// flagged in a sticky bit and counted.
//
// Ports
//   clk            clock, rising edge
//   rst_n          synchronous reset, active HIGH despite the name (1 = reset)
//   wbuf_in_en     write strobe (dtc_out_en)
//   wbuf_in_addr   write address (dtc_out_addr)
//   wbuf_in        write data (dtc_out)
//   wbuf_out_vld   head entry valid
//   wbuf_out_rdy   sink accepts head entry
//   wbuf_out_addr  head entry address
//   wbuf_out       head entry data
//   wbuf_cnt       occupied entries, 0..DEPTH (includes the presented head)
//   wbuf_full      wbuf_cnt == DEPTH
//   wbuf_empty     wbuf_cnt == 0
//   wbuf_ovf       sticky overflow flag
//   wbuf_drop_cnt  dropped writes, saturating
//   wbuf_ovf_clr   clears wbuf_ovf and wbuf_drop_cnt (a same-cycle drop wins)
module dtc_wbuf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wbuf_in_en,
  input  logic [31:0]   wbuf_in_addr,
  input  logic [31:0]   wbuf_in,
  output logic          wbuf_out_vld,
  input  logic          wbuf_out_rdy,
  output logic [31:0]   wbuf_out_addr,
  output logic [31:0]   wbuf_out,
  output logic [PW:0]   wbuf_cnt,
  output logic          wbuf_full,
  output logic          wbuf_empty,
  output logic          wbuf_ovf,
  output logic [15:0]   wbuf_drop_cnt,
  input  logic          wbuf_ovf_clr
);

  localparam int unsigned CW = PW + 1;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  // Storage holds every occupied entry, including the one presented as head.
  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_n, rd_ptr_n, head_idx;
  logic [CW-1:0] cnt_n, avail;
  logic          pop, push, drop;
  logic          vld_n, ovf_n;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] data_n;
  logic [15:0]   drop_cnt_n;

  // Handshake, occupancy and head-register next-state.
  always_comb begin
    pop        = wbuf_out_vld & wbuf_out_rdy;
    push       = wbuf_in_en & (~wbuf_full | pop);
    drop       = wbuf_in_en & ~push;
    wr_ptr_n   = wr_ptr + PW'(push);
    rd_ptr_n   = rd_ptr + PW'(pop);
    head_idx   = rd_ptr + PW'(pop);
    cnt_n      = wbuf_cnt + CW'(push) - CW'(pop);
    // Entries already in storage that remain after this cycle's pop.
    avail      = wbuf_cnt - CW'(pop);
    vld_n      = wbuf_out_vld;
    addr_n     = wbuf_out_addr;
    data_n     = wbuf_out;
    ovf_n      = wbuf_ovf;
    drop_cnt_n = wbuf_drop_cnt;

    // Head registers reload only when idle or when the current head leaves,
    // so they are frozen while vld=1 and rdy=0. A push arriving when nothing
    // older remains is bypassed straight into the head, keeping vld
    // continuous on a simultaneous push/pop at cnt==1.
    if (!wbuf_out_vld || pop) begin
      if (avail != '0) begin
        vld_n  = 1'b1;
        addr_n = mem_addr[head_idx];
        data_n = mem_data[head_idx];
      end else if (push) begin
        vld_n  = 1'b1;
        addr_n = wbuf_in_addr;
        data_n = wbuf_in;
      end else begin
        vld_n  = 1'b0;
      end
    end

    // Clear first, so a drop in the same cycle re-arms the flag and counts 1.
    if (wbuf_ovf_clr) begin
      ovf_n      = 1'b0;
      drop_cnt_n = '0;
    end
    if (drop) begin
      ovf_n = 1'b1;
      if (drop_cnt_n != 16'hFFFF) begin
        drop_cnt_n = drop_cnt_n + 16'd1;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      wbuf_cnt      <= '0;
      wbuf_full     <= 1'b0;
      wbuf_empty    <= 1'b1;
      wbuf_out_vld  <= 1'b0;
      wbuf_out_addr <= '0;
      wbuf_out      <= '0;
      wbuf_ovf      <= 1'b0;
      wbuf_drop_cnt <= '0;
    end else begin
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      wbuf_cnt      <= cnt_n;
      wbuf_full     <= (cnt_n == CW'(DEPTH));
      wbuf_empty    <= (cnt_n == '0);
      wbuf_out_vld  <= vld_n;
      wbuf_out_addr <= addr_n;
      wbuf_out      <= data_n;
      wbuf_ovf      <= ovf_n;
      wbuf_drop_cnt <= drop_cnt_n;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push && !rst_n) begin
      mem_addr[wr_ptr] <= wbuf_in_addr;
      mem_data[wr_ptr] <= wbuf_in;
    end
  end

endmodule

// File: tb/tb_dtc_wbuf.sv
// Testbench for dtc_wbuf: vector table, directed corner sequences and a
// randomized run, all checked against a queue-based model of the buffer.
module tb_dtc_wbuf;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PW    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wbuf_in_en = 1'b0;
  logic [31:0] wbuf_in_addr = '0;
  logic [31:0] wbuf_in = '0;
  logic        wbuf_out_vld;
  logic        wbuf_out_rdy = 1'b0;
  logic [31:0] wbuf_out_addr;
  logic [31:0] wbuf_out;
  logic [PW:0] wbuf_cnt;
  logic        wbuf_full;
  logic        wbuf_empty;
  logic        wbuf_ovf;
  logic [15:0] wbuf_drop_cnt;
  logic        wbuf_ovf_clr = 1'b0;

  dtc_wbuf #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wbuf_in_en    (wbuf_in_en),
    .wbuf_in_addr  (wbuf_in_addr),
    .wbuf_in       (wbuf_in),
    .wbuf_out_vld  (wbuf_out_vld),
    .wbuf_out_rdy  (wbuf_out_rdy),
    .wbuf_out_addr (wbuf_out_addr),
    .wbuf_out      (wbuf_out),
    .wbuf_cnt      (wbuf_cnt),
    .wbuf_full     (wbuf_full),
    .wbuf_empty    (wbuf_empty),
    .wbuf_ovf      (wbuf_ovf),
    .wbuf_drop_cnt (wbuf_drop_cnt),
    .wbuf_ovf_clr  (wbuf_ovf_clr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {addr, data} plus overflow state.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf = 1'b0;
  int unsigned m_dc  = 0;

  task automatic model_update(input logic rst, input logic en, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy, input logic clr);
    logic pop, push, drop;
    ent_t e;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_dc  = 0;
    end else begin
      pop  = (q.size() > 0) && rdy;
      push = en && ((q.size() < DEPTH) || pop);
      drop = en && !push;
      if (pop) void'(q.pop_front());
      if (push) begin
        e.addr = a;
        e.data = d;
        q.push_back(e);
      end
      if (drop) begin
        m_ovf = 1'b1;
        m_dc  = clr ? 1 : ((m_dc < 65535) ? m_dc + 1 : m_dc);
      end else if (clr) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
  endtask

  task automatic model_check();
    chk("vld",   32'(wbuf_out_vld), 32'(q.size() > 0));
    chk("cnt",   32'(wbuf_cnt), 32'(q.size()));
    chk("full",  32'(wbuf_full), 32'(q.size() == DEPTH));
    chk("empty", 32'(wbuf_empty), 32'(q.size() == 0));
    chk("ovf",   32'(wbuf_ovf), 32'(m_ovf));
    chk("drop_cnt", 32'(wbuf_drop_cnt), m_dc);
    if (q.size() > 0) begin
      chk("head_addr", wbuf_out_addr, q[0].addr);
      chk("head_data", wbuf_out, q[0].data);
    end
  endtask

  // One clock: drive, clock edge, update model, sample 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy, input logic clr);
    rst_n        = rst;
    wbuf_in_en   = en;
    wbuf_in_addr = a;
    wbuf_in      = d;
    wbuf_out_rdy = rdy;
    wbuf_ovf_clr = clr;
    @(posedge clk);
    model_update(rst, en, a, d, rdy, clr);
    #1;
    model_check();
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic        exp_vld;
    int          exp_cnt;
    logic [31:0] exp_data;
    logic        exp_ovf;
    int          exp_dc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic en, logic [31:0] a, logic [31:0] d, logic rdy,
                              logic clr, logic ev, int ec, logic [31:0] ed, logic eo, int edc);
    vec_t v;
    v.rst = rst; v.en = en; v.addr = a; v.data = d; v.rdy = rdy; v.clr = clr;
    v.exp_vld = ev; v.exp_cnt = ec; v.exp_data = ed; v.exp_ovf = eo; v.exp_dc = edc;
    return v;
  endfunction

  vec_t        tbl[$];
  logic [31:0] seen[$];
  logic [31:0] hold_a, hold_d;

  initial begin
    // Reset, single push with rdy=1, drain to empty.
    tbl.push_back(mk(1, 0, 32'h0,   32'h0,         0, 0, 0, 0, 32'h0,         0, 0));
    tbl.push_back(mk(0, 1, 32'h100, 32'hA5A5_0001, 1, 0, 1, 1, 32'hA5A5_0001, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h0,         1, 0, 0, 0, 32'h0,         0, 0));
    // Fill to full with head staying at data 1.
    tbl.push_back(mk(1, 0, 32'h0,   32'h0,         0, 0, 0, 0, 32'h0,         0, 0));
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(0, 1, 32'h200 + 32'(i), 32'(i), 0, 0, 1, i, 32'h1, 0, 0));
    // Three drops, then clear together with a fourth drop, then clear alone.
    for (int k = 1; k <= 3; k++)
      tbl.push_back(mk(0, 1, 32'h300, 32'hDEAD_0000 + 32'(k), 0, 0, 1, 8, 32'h1, 1, k));
    tbl.push_back(mk(0, 1, 32'h300, 32'hDEAD_0004, 0, 1, 1, 8, 32'h1, 1, 1));
    tbl.push_back(mk(0, 0, 32'h0,   32'h0,         0, 1, 1, 8, 32'h1, 0, 0));
    tbl.push_back(mk(0, 0, 32'h0,   32'h0,         1, 0, 1, 7, 32'h2, 0, 0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].addr, tbl[i].data, tbl[i].rdy, tbl[i].clr);
      chk("tbl_vld",   32'(wbuf_out_vld), 32'(tbl[i].exp_vld));
      chk("tbl_cnt",   32'(wbuf_cnt), 32'(tbl[i].exp_cnt));
      chk("tbl_empty", 32'(wbuf_empty), 32'(tbl[i].exp_cnt == 0));
      chk("tbl_full",  32'(wbuf_full), 32'(tbl[i].exp_cnt == 8));
      chk("tbl_ovf",   32'(wbuf_ovf), 32'(tbl[i].exp_ovf));
      chk("tbl_dc",    32'(wbuf_drop_cnt), 32'(tbl[i].exp_dc));
      if (tbl[i].exp_vld) chk("tbl_data", wbuf_out, tbl[i].exp_data);
      if (i == 1) chk("tbl_addr", wbuf_out_addr, 32'h100);
    end

    // Overflow by one, then drain in order; data 9 must never appear.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) step(0, 1, 32'(i * 4), 32'(i), 0, 0);
    chk("ovf9_full", 32'(wbuf_full), 32'h1);
    chk("ovf9_dc", 32'(wbuf_drop_cnt), 32'h1);
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      if (wbuf_out_vld) seen.push_back(wbuf_out);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("drain_len", 32'(seen.size()), 32'd8);
    foreach (seen[i]) chk("drain_order", seen[i], 32'(i + 1));

    // Push while full with a simultaneous pop: accepted, 0xBEEF drains last.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 32'h400 + 32'(i), 32'h10 + 32'(i), 0, 0);
    step(0, 1, 32'h4FF, 32'hBEEF, 1, 0);
    chk("full_pp_cnt", 32'(wbuf_cnt), 32'd8);
    chk("full_pp_dc", 32'(wbuf_drop_cnt), 32'd0);
    seen.delete();
    for (int i = 0; i < 9; i++) begin
      if (wbuf_out_vld) seen.push_back(wbuf_out);
      step(0, 0, 0, 0, 1, 0);
    end
    chk("full_pp_len", 32'(seen.size()), 32'd8);
    if (seen.size() > 0) chk("full_pp_last", seen[seen.size() - 1], 32'hBEEF);

    // Push and pop at cnt==1: vld stays high and the new entry is head.
    step(0, 1, 32'h500, 32'h51, 0, 0);
    step(0, 1, 32'h504, 32'h52, 1, 0);
    chk("cnt1_vld", 32'(wbuf_out_vld), 32'h1);
    chk("cnt1_head", wbuf_out, 32'h52);

    // Stall: head stable for 5 cycles while 3 pushes arrive.
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h700, 32'h77, 0, 0);
    hold_a = wbuf_out_addr;
    hold_d = wbuf_out;
    for (int i = 0; i < 5; i++) begin
      step(0, (i % 2) == 0, 32'h710 + 32'(i), 32'h80 + 32'(i), 0, 0);
      chk("stall_addr", wbuf_out_addr, hold_a);
      chk("stall_data", wbuf_out, hold_d);
    end
    chk("stall_cnt", 32'(wbuf_cnt), 32'd4);

    // Reset mid-drain with cnt=5: everything discarded.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 32'h900 + 32'(i), 32'h90 + 32'(i), 0, 0);
    chk("prerst_cnt", 32'(wbuf_cnt), 32'd5);
    step(1, 0, 0, 0, 1, 0);
    chk("rst_vld", 32'(wbuf_out_vld), 32'h0);
    chk("rst_cnt", 32'(wbuf_cnt), 32'h0);
    chk("rst_empty", 32'(wbuf_empty), 32'h1);
    chk("rst_data", wbuf_out, 32'h0);
    step(0, 1, 32'hA00, 32'hC0DE, 0, 0);
    chk("postrst_head", wbuf_out, 32'hC0DE);

    // Randomized traffic under varying sink readiness.
    for (int seg = 0; seg < 4; seg++) begin
      int pr;
      pr = (seg == 0) ? 20 : (seg == 1) ? 50 : (seg == 2) ? 90 : 70;
      for (int c = 0; c < 500; c++) begin
        step($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom,
             $urandom_range(0, 99) < pr, $urandom_range(0, 19) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
